mem_dump_ctrl: RTL and testbench

Parametrised memory-inspection controller that sits between the processor's address/write-enable outputs and the RAM. It generalises the single-increment dump counter and its address mux. Features:
- configurable address/data widths
- programmable start/end range with wrap-around
- increment or decrement direction
- manual single-step or timed auto-scan
- processor RAM writes blocked while a dump is active

Its outputs drive the RAM address, RAM write-enable and the display controller.

---
 rtl/mem_dump_ctrl.sv | 119 +++++++++++
 tb/tb_mem_dump_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// Memory-inspection controller: steps a dump pointer through a programmable address range
// and takes over the RAM address/write-enable from the processor while a dump is active.
module mem_dump_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int SCAN_DIV = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_en,
    input  logic              step,
    input  logic              auto_en,
    input  logic              dir,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_active,
    output logic              wrap_pulse,
    output logic              wr_blocked
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, ARM, DUMP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] lo, hi;
    logic [CNT_W-1:0]  scan_cnt;
    logic              step_q;
    logic              step_edge;
    logic              auto_tick;
    logic              advance;

    // Returns {wrap, next pointer}; a pointer left outside the range by a bound change
    // re-enters at the starting end without signalling a wrap.
    function automatic logic [ADDR_W:0] next_ptr(input logic [ADDR_W-1:0] p,
                                                 input logic [ADDR_W-1:0] lo_b,
                                                 input logic [ADDR_W-1:0] hi_b,
                                                 input logic              d);
        if (p < lo_b || p > hi_b)
            return {1'b0, (d ? hi_b : lo_b)};
        if (!d)
            return (p == hi_b) ? {1'b1, lo_b} : {1'b0, p + ADDR_W'(1)};
        return (p == lo_b) ? {1'b1, hi_b} : {1'b0, p - ADDR_W'(1)};
    endfunction

    assign lo        = (start_addr < end_addr) ? start_addr : end_addr;
    assign hi        = (start_addr < end_addr) ? end_addr : start_addr;
    assign step_edge = step & ~step_q;
    assign auto_tick = auto_en && (scan_cnt == CNT_LAST);
    assign advance   = (state == DUMP) && dump_en && (step_edge || auto_tick);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dump_en) state_nxt = ARM;
            ARM:     state_nxt = dump_en ? DUMP : IDLE;
            DUMP:    if (!dump_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dump_active = (state != IDLE);
        mem_addr    = dump_active ? dump_addr : cpu_addr;
        mem_we      = dump_active ? 1'b0 : cpu_we;
    end

    always_ff @(posedge clk) begin
        if (reset || state == ARM || !auto_en)
            scan_cnt <= '0;
        else if (scan_cnt == CNT_LAST)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q     <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            wrap_pulse <= 1'b0;
            wr_blocked <= 1'b0;
        end else begin
            step_q     <= step;
            wrap_pulse <= 1'b0;
            case (state)
                ARM: begin
                    dump_addr  <= dir ? hi : lo;
                    wr_blocked <= 1'b0;
                end
                DUMP: begin
                    dump_data <= mem_din;
                    if (cpu_we)
                        wr_blocked <= 1'b1;
                    if (advance)
                        {wrap_pulse, dump_addr} <= next_ptr(dump_addr, lo, hi, dir);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed bench for mem_dump_ctrl with a small synchronous RAM model (data = {A5, addr}).
module tb_mem_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset, dump_en, step, auto_en, dir, cpu_we;
    logic [7:0]  start_addr, end_addr, cpu_addr;
    logic [15:0] mem_din = 16'h0000;
    logic [7:0]  mem_addr, dump_addr;
    logic [15:0] dump_data;
    logic        mem_we, dump_active, wrap_pulse, wr_blocked;

    int checks   = 0;
    int failures = 0;

    mem_dump_ctrl #(.ADDR_W(8), .DATA_W(16), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .dump_en(dump_en), .step(step), .auto_en(auto_en),
        .dir(dir), .start_addr(start_addr), .end_addr(end_addr), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .mem_din(mem_din), .mem_addr(mem_addr), .mem_we(mem_we),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_active(dump_active),
        .wrap_pulse(wrap_pulse), .wr_blocked(wr_blocked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_din <= {8'hA5, mem_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; dump_en = 1'b0; step = 1'b0; auto_en = 1'b0; dir = 1'b0;
        start_addr = 8'h00; end_addr = 8'h00; cpu_addr = 8'h3C; cpu_we = 1'b1;
        tick(); tick();
        checks++; if (mem_addr !== 8'h3C) begin failures++; $display("FAIL reset_mem_addr got=%h exp=3c", mem_addr); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL reset_mem_we got=%b exp=1", mem_we); end
        checks++; if (dump_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", dump_active); end
        checks++; if (dump_addr !== 8'h00) begin failures++; $display("FAIL reset_dump_addr got=%h exp=00", dump_addr); end
        checks++; if (dump_data !== 16'h0000) begin failures++; $display("FAIL reset_dump_data got=%h exp=0000", dump_data); end
        checks++; if ({wrap_pulse, wr_blocked} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {wrap_pulse, wr_blocked}); end
        reset = 1'b0; cpu_we = 1'b0;
        tick();
    endtask

    task automatic test_step_inc();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h12; exp_seq[2] = 8'h10;
        start_addr = 8'h10; end_addr = 8'h12; dir = 1'b0; dump_en = 1'b1;
        tick();
        checks++; if (dump_active !== 1'b1) begin failures++; $display("FAIL arm_active got=%b exp=1", dump_active); end
        tick();
        checks++; if (dump_addr !== 8'h10) begin failures++; $display("FAIL arm_load got=%h exp=10", dump_addr); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL dump_mem_addr got=%h exp=10", mem_addr); end
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick();
            checks++; if (dump_addr !== exp_seq[i]) begin failures++; $display("FAIL step_inc_%0d got=%h exp=%h", i, dump_addr, exp_seq[i]); end
            checks++; if (wrap_pulse !== (i == 2)) begin failures++; $display("FAIL step_wrap_%0d got=%b exp=%b", i, wrap_pulse, (i == 2)); end
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL step_mem_we_%0d got=%b exp=0", i, mem_we); end
            step = 1'b0; tick();
        end
        checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap_pulse); end
        tick();
        checks++; if (dump_data !== 16'hA510) begin failures++; $display("FAIL dump_data got=%h exp=a510", dump_data); end
    endtask

    task automatic test_auto_dec();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h04; exp_seq[1] = 8'h03; exp_seq[2] = 8'h02; exp_seq[3] = 8'h05;
        dump_en = 1'b0; tick();
        checks++; if (dump_active !== 1'b0) begin failures++; $display("FAIL exit_idle got=%b exp=0", dump_active); end
        start_addr = 8'h05; end_addr = 8'h02; dir = 1'b1; auto_en = 1'b1; dump_en = 1'b1;
        tick(); tick();
        checks++; if (dump_addr !== 8'h05) begin failures++; $display("FAIL auto_load got=%h exp=05", dump_addr); end
        for (int i = 0; i < 4; i++) begin
            tick(); tick(); tick();
            checks++; if (dump_addr !== (i == 0 ? 8'h05 : exp_seq[i-1])) begin failures++; $display("FAIL auto_hold_%0d got=%h", i, dump_addr); end
            tick();
            checks++; if (dump_addr !== exp_seq[i]) begin failures++; $display("FAIL auto_dec_%0d got=%h exp=%h", i, dump_addr, exp_seq[i]); end
            checks++; if (wrap_pulse !== (i == 3)) begin failures++; $display("FAIL auto_wrap_%0d got=%b exp=%b", i, wrap_pulse, (i == 3)); end
        end
    endtask

    task automatic test_coincident();
        tick(); tick(); tick();
        step = 1'b1; tick();
        checks++; if (dump_addr !== 8'h04) begin failures++; $display("FAIL coincident got=%h exp=04", dump_addr); end
        step = 1'b0; auto_en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (dump_addr !== 8'h04) begin failures++; $display("FAIL auto_off_hold got=%h exp=04", dump_addr); end
        dump_en = 1'b0; tick();
        start_addr = 8'h10; end_addr = 8'h12; dir = 1'b0; dump_en = 1'b1;
        tick();
        step = 1'b1; tick();
        checks++; if (dump_addr !== 8'h10) begin failures++; $display("FAIL arm_step_ignored got=%h exp=10", dump_addr); end
        tick();
        checks++; if (dump_addr !== 8'h10) begin failures++; $display("FAIL step_level_no_adv got=%h exp=10", dump_addr); end
        step = 1'b0; tick();
    endtask

    task automatic test_wr_block();
        cpu_we = 1'b1; cpu_addr = 8'h3C; #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL block_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL block_mem_addr got=%h exp=10", mem_addr); end
        tick();
        checks++; if (wr_blocked !== 1'b1) begin failures++; $display("FAIL wr_blocked_set got=%b exp=1", wr_blocked); end
        cpu_we = 1'b0; tick();
        checks++; if (wr_blocked !== 1'b1) begin failures++; $display("FAIL wr_blocked_sticky got=%b exp=1", wr_blocked); end
        dump_en = 1'b0; step = 1'b1; tick();
        checks++; if (dump_active !== 1'b0) begin failures++; $display("FAIL exit_active got=%b exp=0", dump_active); end
        checks++; if (mem_addr !== 8'h3C) begin failures++; $display("FAIL exit_mem_addr got=%h exp=3c", mem_addr); end
        checks++; if (dump_addr !== 8'h10) begin failures++; $display("FAIL exit_no_adv got=%h exp=10", dump_addr); end
        checks++; if (wr_blocked !== 1'b1) begin failures++; $display("FAIL idle_sticky got=%b exp=1", wr_blocked); end
        step = 1'b0; dump_en = 1'b1; tick(); tick();
        checks++; if (wr_blocked !== 1'b0) begin failures++; $display("FAIL arm_clear got=%b exp=0", wr_blocked); end
    endtask

    task automatic test_out_of_range();
        start_addr = 8'h30; end_addr = 8'h20;
        step = 1'b1; tick();
        checks++; if (dump_addr !== 8'h20) begin failures++; $display("FAIL oor_reload got=%h exp=20", dump_addr); end
        checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL oor_nowrap got=%b exp=0", wrap_pulse); end
        step = 1'b0; start_addr = 8'h20; end_addr = 8'h20; tick();
        step = 1'b1; tick();
        checks++; if ({wrap_pulse, dump_addr} !== 9'h120) begin failures++; $display("FAIL lo_eq_hi got=%h exp=120", {wrap_pulse, dump_addr}); end
        step = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        cpu_we = 1'b1; tick();
        cpu_we = 1'b0; reset = 1'b1; step = 1'b1; tick();
        checks++; if (dump_active !== 1'b0) begin failures++; $display("FAIL rst_mid_active got=%b exp=0", dump_active); end
        checks++; if (dump_addr !== 8'h00) begin failures++; $display("FAIL rst_mid_addr got=%h exp=00", dump_addr); end
        checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL rst_mid_wrap got=%b exp=0", wrap_pulse); end
        checks++; if (wr_blocked !== 1'b0) begin failures++; $display("FAIL rst_mid_blocked got=%b exp=0", wr_blocked); end
        reset = 1'b0; step = 1'b0; dump_en = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_step_inc();
        test_auto_dec();
        test_coincident();
        test_wr_block();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
